timer_irq_ctrl: RTL and testbench
=================================

Name: timer_irq_ctrl

Overview:
- Sits between the CPU's memory-mapped I/O port and the shared device bus that the timer and the other peripherals hang on.
- Polls the timer control register (TCTL) and raises an interrupt when its READY bit is set. After the CPU acknowledges, it clears TCTL by writing 0.
- Arbitrates each device-bus cycle between CPU accesses and its own poll/clear accesses, with a starvation guard.
- Exposes one local status register for the CPU.

Parameters:
- TCTL_ADDR, 32'hF0000120, device-bus address of the timer control register
- ISTAT_ADDR, 32'hF0000140, local status register address; never forwarded to the device bus
- READY, 0, TCTL bit index of the ready flag
- OVERRUN, 2, TCTL bit index of the overrun flag
- POLL_PERIOD, 32'd8, IDLE cycles between polls (must be ≥1)
- STARVE_LIM, 8'd4, consecutive lost arbitrations before the controller forces a win (must be ≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_abus  in  32  CPU address
- cpu_wren  in  1  CPU write enable
- cpu_dbus_in  in  32  CPU write data
- cpu_dbus_out  out  32  CPU read data; valid in the cpu_ack cycle, else 0
- cpu_ack  out  1  CPU access granted this cycle (combinational)
- dev_abus  out  32  device-bus address
- dev_wren  out  1  device-bus write enable
- dev_dbus_out  out  32  device-bus write data
- dev_dbus_in  in  32  device-bus read data (devices drive it combinationally)
- irq  out  1  interrupt to CPU (registered)
- irq_ack  in  1  CPU interrupt acknowledge, single-cycle pulse

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - FSM = IDLE; irq = 0; ovr_sticky = 0; poll_cnt = 0; wait_cnt = 0.
  - While rst is high: dev_wren = 0 and cpu_ack = 0. All other combinational outputs are 0.
  - rst mid-operation abandons any poll or clear; no device write is issued in the rst cycle.
- FSM states: IDLE, POLL, WAIT_ACK, CLEAR.
  - IDLE: poll_cnt increments each cycle. When poll_cnt == POLL_PERIOD-1, go to POLL and reset poll_cnt to 0. poll_cnt is held at 0 outside IDLE.
  - POLL: controller requests a read at TCTL_ADDR. On its grant cycle it samples dev_dbus_in:
    - READY bit = 1: go to WAIT_ACK and set irq = 1 next cycle. If the OVERRUN bit = 1, set ovr_sticky = 1.
    - READY bit = 0: go to IDLE.
  - WAIT_ACK: irq held at 1. When irq_ack = 1, go to CLEAR.
  - CLEAR: controller requests a write of 32'b0 to TCTL_ADDR. On its grant cycle, irq = 0 next cycle and go to IDLE.
  - irq_ack outside WAIT_ACK is ignored.
- Arbitration (combinational, evaluated per cycle):
  - The controller requests the bus only in POLL or CLEAR.
  - CPU accesses to ISTAT_ADDR are local, never conflict, and always get cpu_ack = 1 in the request cycle.
  - Otherwise the CPU wins if cpu_req = 1 and wait_cnt < STARVE_LIM; else the controller wins if it is requesting.
  - wait_cnt increments when the controller is requesting and loses. It clears on a controller grant.
  - At most one owner per cycle. The loser's access is retried the next cycle.
- Device-bus mux:
  - Owner's address, write enable and write data drive dev_abus, dev_wren and dev_dbus_out.
  - With no owner: all zero.
  - dev_wren is never 1 for an ISTAT_ADDR access.
- CPU read data, in the cpu_ack cycle with cpu_wren = 0:
  - ISTAT_ADDR: {30'b0, ovr_sticky, irq}.
  - Any other address: dev_dbus_in.
- CPU write of 0 to ISTAT_ADDR clears ovr_sticky. If a poll sets ovr_sticky in the same cycle, the set wins.
- A CPU write to TCTL during WAIT_ACK is forwarded as normal. The FSM still performs its own CLEAR write.

Optional Feature:
- Macro: TIMER_IRQ_CTRL_AUTO_ACK_EN.
- Defined:
  - POLL with READY = 1 goes straight to CLEAR.
  - irq is a one-cycle pulse, asserted the cycle after detection.
  - irq_ack is ignored and WAIT_ACK is unreachable.
- Undefined: behaviour as above.

Test Plan:
- Reset → all outputs 0; with no cpu_req, the first TCTL read appears on dev_abus exactly 8 cycles after rst falls (POLL_PERIOD=8).
- dev_dbus_in = 32'h1 on poll → irq = 1 next cycle. irq_ack pulse → next cycle dev_abus = 32'hF0000120, dev_wren = 1, dev_dbus_out = 0. irq = 0 the cycle after.
- dev_dbus_in = 32'h5 on poll → ISTAT read returns 32'h3. CPU writes 0 to ISTAT after the clear completes → ISTAT read returns 32'h0.
- cpu_req held high continuously while FSM is in POLL → CPU acked 4 cycles, controller granted on the 5th (cpu_ack = 0), then CPU resumes.
- Assert rst while in CLEAR with CPU holding the bus → no device write is issued; FSM returns to IDLE, irq = 0.
- With TIMER_IRQ_CTRL_AUTO_ACK_EN defined, dev_dbus_in = 32'h1 → irq high exactly 1 cycle; TCTL write of 0 follows with no irq_ack.

Source files
------------

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl
// Sits between the CPU memory-mapped I/O port and the shared device bus.
// It polls the timer control register (TCTL) and raises irq when the READY
// bit is set. Once the CPU acknowledges, it clears TCTL by writing 0. Each
// device-bus cycle is arbitrated between the CPU and the controller's own
// poll and clear accesses, with a starvation guard for the controller. One
// local status register (ISTAT) is served without touching the device bus.
//
// Optional build macro: TIMER_IRQ_CTRL_AUTO_ACK_EN
//   When defined, a ready poll goes straight to CLEAR and irq becomes a
//   one-cycle pulse. irq_ack is ignored and WAIT_ACK is never entered.
//
// Handshake: cpu_req is held with stable address and data until a cycle in
// which cpu_ack=1. That cycle completes the access; read data is valid on
// cpu_dbus_out only in that cycle. A CPU access that loses arbitration sees
// cpu_ack=0 and simply retries the next cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cpu_req         CPU access request, held until cpu_ack
//   cpu_abus        CPU address
//   cpu_wren        CPU write enable
//   cpu_dbus_in     CPU write data
//   cpu_dbus_out    CPU read data (cpu_ack cycle only, else 0)
//   cpu_ack         CPU access completes this cycle (combinational)
//   dev_abus        device-bus address
//   dev_wren        device-bus write enable
//   dev_dbus_out    device-bus write data
//   dev_dbus_in     device-bus read data (combinational from devices)
//   irq             interrupt to CPU (registered)
//   irq_ack         CPU interrupt acknowledge, single-cycle pulse
//   dbg_state       current FSM state (0 IDLE, 1 POLL, 2 WAIT_ACK, 3 CLEAR)
module timer_irq_ctrl #(
  parameter logic [31:0] TCTL_ADDR   = 32'hF0000120,
  parameter logic [31:0] ISTAT_ADDR  = 32'hF0000140,
  parameter int          READY       = 0,
  parameter int          OVERRUN     = 2,
  parameter logic [31:0] POLL_PERIOD = 32'd8,
  parameter logic [7:0]  STARVE_LIM  = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_abus,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_dbus_in,
  output logic [31:0] cpu_dbus_out,
  output logic        cpu_ack,
  output logic [31:0] dev_abus,
  output logic        dev_wren,
  output logic [31:0] dev_dbus_out,
  input  logic [31:0] dev_dbus_in,
  output logic        irq,
  input  logic        irq_ack,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_POLL     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_CLEAR    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        irq_q, irq_d;
  logic        ovr_q, ovr_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic ctl_req;
  logic cpu_local;
  logic cpu_win;
  logic ctl_grant;
  logic poll_hit;

  // Arbitration. ISTAT accesses never touch the device bus, so they do not
  // compete with the controller. Everything is forced idle while rst is high
  // so no device write can escape in the reset cycle.
  always_comb begin
    ctl_req   = !rst && (state_q == S_POLL || state_q == S_CLEAR);
    cpu_local = !rst && cpu_req && (cpu_abus == ISTAT_ADDR);
    cpu_win   = !rst && cpu_req && !cpu_local && (wait_cnt_q < STARVE_LIM);
    ctl_grant = ctl_req && !cpu_win;
    poll_hit  = ctl_grant && (state_q == S_POLL) && dev_dbus_in[READY];
  end

  // Device-bus mux and CPU-facing outputs.
  always_comb begin
    cpu_ack      = cpu_local || cpu_win;
    cpu_dbus_out = '0;
    dev_abus     = '0;
    dev_wren     = 1'b0;
    dev_dbus_out = '0;
    if (cpu_win) begin
      dev_abus     = cpu_abus;
      dev_wren     = cpu_wren;
      dev_dbus_out = cpu_dbus_in;
    end else if (ctl_grant) begin
      dev_abus     = TCTL_ADDR;
      dev_wren     = (state_q == S_CLEAR);
      dev_dbus_out = '0;
    end
    if (cpu_ack && !cpu_wren) begin
      cpu_dbus_out = cpu_local ? {30'b0, ovr_q, irq_q} : dev_dbus_in;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    ovr_d      = ovr_q;
    poll_cnt_d = '0;
    wait_cnt_d = wait_cnt_q;

    if (ctl_grant) begin
      wait_cnt_d = '0;
    end else if (ctl_req) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Clear first so that a same-cycle overrun set takes priority.
    if (cpu_local && cpu_wren && (cpu_dbus_in == '0)) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (poll_cnt_q == POLL_PERIOD - 32'd1) begin
          state_d = S_POLL;
        end else begin
          poll_cnt_d = poll_cnt_q + 32'd1;
        end
      end
      S_POLL: begin
        if (ctl_grant) begin
          if (dev_dbus_in[READY]) begin
            irq_d = 1'b1;
            if (dev_dbus_in[OVERRUN]) begin
              ovr_d = 1'b1;
            end
`ifdef TIMER_IRQ_CTRL_AUTO_ACK_EN
            state_d = S_CLEAR;
`else
            state_d = S_WAIT_ACK;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_ACK: begin
        if (irq_ack) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (ctl_grant) begin
          irq_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TIMER_IRQ_CTRL_AUTO_ACK_EN
    // irq is only a pulse on the cycle after detection.
    irq_d = poll_hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      poll_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
      poll_cnt_q <= poll_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign irq       = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Testbench for timer_irq_ctrl: directed scenarios followed by randomized
// CPU/timer traffic. A reference model predicts every output per cycle; the
// prediction goes into exp_q and a monitor compares on the falling edge.
module tb_timer_irq_ctrl;

  localparam logic [31:0] TCTL   = 32'hF0000120;
  localparam logic [31:0] ISTAT  = 32'hF0000140;
  localparam int          PERIOD = 8;
  localparam int          STARVE = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_POLL  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_CLEAR = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_abus;
  logic        cpu_wren;
  logic [31:0] cpu_dbus_in;
  logic [31:0] cpu_dbus_out;
  logic        cpu_ack;
  logic [31:0] dev_abus;
  logic        dev_wren;
  logic [31:0] dev_dbus_out;
  logic [31:0] dev_dbus_in;
  logic        irq;
  logic        irq_ack;
  logic [1:0]  dbg_state;

  timer_irq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_abus     (cpu_abus),
    .cpu_wren     (cpu_wren),
    .cpu_dbus_in  (cpu_dbus_in),
    .cpu_dbus_out (cpu_dbus_out),
    .cpu_ack      (cpu_ack),
    .dev_abus     (dev_abus),
    .dev_wren     (dev_wren),
    .dev_dbus_out (dev_dbus_out),
    .dev_dbus_in  (dev_dbus_in),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Packed expectation: {ack, rd[31:0], abus[31:0], wren, wdata[31:0], irq}
  logic [98:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: timer-controller behaviour in plain terms.
  int m_phase = PH_IDLE;
  int m_idle  = 0;   // idle cycles counted toward the next poll
  int m_lost  = 0;   // consecutive lost arbitrations of the controller
  bit m_irq   = 1'b0;
  bit m_ovr   = 1'b0;
  bit m_ack   = 1'b0;  // predicted cpu_ack of the last driven cycle

  // Values observed on the falling edge of the last driven cycle.
  logic        cap_ack;
  logic [31:0] cap_rd;
  logic [31:0] cap_abus;
  logic        cap_we;
  logic [31:0] cap_wd;
  logic        cap_irq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick(input bit r, input bit req, input logic [31:0] a, input bit we,
                      input logic [31:0] wd, input logic [31:0] din, input bit iack);
    bit          ctl_wants, local_acc, cpu_bus, ctl_gets, hit;
    bit          e_ack, e_we;
    logic [31:0] e_rd, e_abus, e_wd;
    int          nphase;
    rst         = r;
    cpu_req     = req;
    cpu_abus    = a;
    cpu_wren    = we;
    cpu_dbus_in = wd;
    dev_dbus_in = din;
    irq_ack     = iack;

    e_ack = 1'b0; e_we = 1'b0; e_rd = '0; e_abus = '0; e_wd = '0;
    if (r) begin
      exp_q.push_back({e_ack, e_rd, e_abus, e_we, e_wd, m_irq});
      m_phase = PH_IDLE; m_idle = 0; m_lost = 0; m_irq = 1'b0; m_ovr = 1'b0;
    end else begin
      ctl_wants = (m_phase == PH_POLL) || (m_phase == PH_CLEAR);
      local_acc = req && (a == ISTAT);
      cpu_bus   = req && !local_acc && (m_lost < STARVE);
      ctl_gets  = ctl_wants && !cpu_bus;
      e_ack     = local_acc || cpu_bus;
      if (cpu_bus) begin
        e_abus = a; e_we = we; e_wd = wd;
      end else if (ctl_gets) begin
        e_abus = TCTL; e_we = (m_phase == PH_CLEAR); e_wd = '0;
      end
      if (e_ack && !we) e_rd = local_acc ? {30'b0, m_ovr, m_irq} : din;
      exp_q.push_back({e_ack, e_rd, e_abus, e_we, e_wd, m_irq});

      if (ctl_gets) m_lost = 0;
      else if (ctl_wants) m_lost++;
      if (local_acc && we && wd == 32'h0) m_ovr = 1'b0;

      hit    = 1'b0;
      nphase = m_phase;
      if (m_phase == PH_IDLE) begin
        if (m_idle == PERIOD - 1) begin nphase = PH_POLL; m_idle = 0; end
        else m_idle++;
      end else if (m_phase == PH_POLL && ctl_gets) begin
        if (din[0]) begin
          hit = 1'b1;
          if (din[2]) m_ovr = 1'b1;
`ifdef TIMER_IRQ_CTRL_AUTO_ACK_EN
          nphase = PH_CLEAR;
`else
          nphase = PH_WAIT;
          m_irq  = 1'b1;
`endif
        end else begin
          nphase = PH_IDLE;
        end
      end else if (m_phase == PH_WAIT && iack) begin
        nphase = PH_CLEAR;
      end else if (m_phase == PH_CLEAR && ctl_gets) begin
        nphase = PH_IDLE;
        m_irq  = 1'b0;
      end
`ifdef TIMER_IRQ_CTRL_AUTO_ACK_EN
      m_irq = hit;
`endif
      m_phase = nphase;
    end
    m_ack = e_ack;

    @(negedge clk);
    cap_ack = cpu_ack; cap_rd = cpu_dbus_out; cap_abus = dev_abus;
    cap_we = dev_wren; cap_wd = dev_dbus_out; cap_irq = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, '0, 0, '0, '0, 0);
    tick(1, 0, '0, 0, '0, '0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [98:0] e;
    logic [98:0] g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {cpu_ack, cpu_dbus_out, dev_abus, dev_wren, dev_dbus_out, irq};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL cycle_outputs t=%0t got ack=%b rd=%h abus=%h we=%b wd=%h irq=%b want ack=%b rd=%h abus=%h we=%b wd=%h irq=%b",
                   $time, g[98], g[97:66], g[65:34], g[33], g[32:1], g[0],
                   e[98], e[97:66], e[65:34], e[33], e[32:1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          first;
    logic [5:0]  pat;
    bit          pend;
    logic [31:0] pa, pd;
    bit          pw;
    bit          last_iack;
    bit          r;
    logic [31:0] din;
    int          sel;

    rst = 1'b1; cpu_req = 1'b0; cpu_abus = '0; cpu_wren = 1'b0;
    cpu_dbus_in = '0; dev_dbus_in = '0; irq_ack = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and first-poll latency.
    do_reset();
    check("reset_irq", {31'b0, cap_irq}, 32'h0);
    check("reset_wren", {31'b0, cap_we}, 32'h0);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, '0, 0, '0, '0, 0);
      if (first < 0 && cap_abus == TCTL) first = i;
    end
    check("first_poll_latency", first, 32'd8);

    // Ready poll, irq, acknowledge, clear write.
    do_reset();
    idle(PERIOD);
    tick(0, 0, '0, 0, '0, 32'h1, 0);
    tick(0, 0, '0, 0, '0, '0, 0);
    check("irq_after_ready", {31'b0, cap_irq}, 32'h1);
`ifdef TIMER_IRQ_CTRL_AUTO_ACK_EN
    check("auto_clear_addr", cap_abus, TCTL);
    check("auto_clear_we", {31'b0, cap_we}, 32'h1);
    tick(0, 0, '0, 0, '0, '0, 0);
    check("auto_irq_pulse_end", {31'b0, cap_irq}, 32'h0);
`else
    tick(0, 0, '0, 0, '0, '0, 1);
    tick(0, 0, '0, 0, '0, '0, 0);
    check("clear_addr", cap_abus, TCTL);
    check("clear_we", {31'b0, cap_we}, 32'h1);
    check("clear_data", cap_wd, 32'h0);
    tick(0, 0, '0, 0, '0, '0, 0);
    check("irq_dropped", {31'b0, cap_irq}, 32'h0);
`endif

    // Overrun sticky bit seen through ISTAT, then cleared by CPU.
    do_reset();
    idle(PERIOD);
    tick(0, 0, '0, 0, '0, 32'h5, 0);
    tick(0, 1, ISTAT, 0, '0, '0, 0);
    check("istat_ovr_irq", cap_rd, 32'h3);
    tick(0, 0, '0, 0, '0, '0, 1);
    idle(2);
    tick(0, 1, ISTAT, 1, 32'h0, '0, 0);
    tick(0, 1, ISTAT, 0, '0, '0, 0);
    check("istat_cleared", cap_rd, 32'h0);

    // Starvation guard: CPU holds the bus while the controller polls.
    do_reset();
    idle(PERIOD);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 32'h0000_1000, 0, '0, 32'h0, 0);
      pat = {pat[4:0], cap_ack};
    end
    check("starve_ack_pattern", {26'b0, pat}, 32'h3D);

    // Reset while the controller wants to clear and the CPU owns the bus.
    do_reset();
    idle(PERIOD);
    tick(0, 0, '0, 0, '0, 32'h1, 0);
`ifndef TIMER_IRQ_CTRL_AUTO_ACK_EN
    tick(0, 0, '0, 0, '0, '0, 1);
`endif
    tick(0, 1, 32'h0000_2000, 0, '0, 32'h1234, 0);
    tick(1, 1, 32'h0000_2000, 0, '0, 32'h1234, 0);
    check("rst_no_dev_write", {31'b0, cap_we}, 32'h0);
    check("rst_no_ack", {31'b0, cap_ack}, 32'h0);
    tick(0, 0, '0, 0, '0, '0, 0);
    check("rst_irq_low", {31'b0, cap_irq}, 32'h0);

    // Randomized traffic.
    do_reset();
    pend = 1'b0; pa = '0; pd = '0; pw = 1'b0; last_iack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if (r) pend = 1'b0;
      else if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        sel  = $urandom_range(0, 2);
        pa   = (sel == 0) ? TCTL : (sel == 1) ? ISTAT : {16'h0, 16'($urandom)};
        pw   = $urandom_range(0, 1) == 1;
        pd   = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
      end
      sel = $urandom_range(0, 9);
      din = (sel < 3) ? 32'h0 : (sel < 6) ? 32'h1 : (sel < 7) ? 32'h5 :
            (sel < 8) ? 32'h4 : $urandom;
      irq_ack = 1'b0;
      last_iack = !last_iack && (m_irq ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 29) == 0));
      tick(r, pend && !r, pa, pw, pd, din, last_iack);
      if (m_ack) pend = 1'b0;
    end

    idle(2);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
